// File: rtl/alu_pkg.sv
// Shared opcode, state and output-select definitions for the sequenced ALU.
package alu_pkg;

  localparam logic [2:0] FS_ADD = 3'b000;
  localparam logic [2:0] FS_SUB = 3'b001;
  localparam logic [2:0] FS_SRA = 3'b010;
  localparam logic [2:0] FS_SRL = 3'b011;
  localparam logic [2:0] FS_SLL = 3'b100;
  localparam logic [2:0] FS_AND = 3'b101;
  localparam logic [2:0] FS_OR  = 3'b110;
  localparam logic [2:0] FS_ILL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OSEL_ADD   = 2'd0;
  localparam logic [1:0] OSEL_SHIFT = 2'd1;
  localparam logic [1:0] OSEL_LOGIC = 2'd2;
  localparam logic [1:0] OSEL_ERR   = 2'd3;

endpackage

// File: rtl/alu_seq_decode.sv
// Function-select decoder: turns the 3-bit FS opcode into datapath controls.
module alu_seq_decode
  import alu_pkg::*;
(
  input  logic [2:0] FS,
  output logic       BSEL,
  output logic       CISEL,
  output logic [1:0] OSEL,
  output logic       SHIFT_LA,
  output logic       SHIFT_LR,
  output logic       LOGICAL_OA,
  output logic       IS_SHIFT,
  output logic       ILLEGAL
);

  // SHIFT_LA = arithmetic fill, SHIFT_LR = right shift, LOGICAL_OA = OR (else AND)
  always_comb begin
    BSEL       = 1'b0;
    CISEL      = 1'b0;
    OSEL       = OSEL_ADD;
    SHIFT_LA   = 1'b0;
    SHIFT_LR   = 1'b0;
    LOGICAL_OA = 1'b0;
    IS_SHIFT   = 1'b0;
    ILLEGAL    = 1'b0;
    case (FS)
      FS_ADD: OSEL = OSEL_ADD;
      FS_SUB: begin
        OSEL  = OSEL_ADD;
        BSEL  = 1'b1;
        CISEL = 1'b1;
      end
      FS_SRA: begin
        OSEL     = OSEL_SHIFT;
        IS_SHIFT = 1'b1;
        SHIFT_LA = 1'b1;
        SHIFT_LR = 1'b1;
      end
      FS_SRL: begin
        OSEL     = OSEL_SHIFT;
        IS_SHIFT = 1'b1;
        SHIFT_LR = 1'b1;
      end
      FS_SLL: begin
        OSEL     = OSEL_SHIFT;
        IS_SHIFT = 1'b1;
      end
      FS_AND: OSEL = OSEL_LOGIC;
      FS_OR: begin
        OSEL       = OSEL_LOGIC;
        LOGICAL_OA = 1'b1;
      end
      default: begin
        OSEL    = OSEL_ERR;
        ILLEGAL = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle add/sub/logic, multi-cycle shifts at STEP bits per cycle.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       FS,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             COUT,
  output logic             OVF,
  output logic             ZERO,
  output logic             ERR
);

  localparam logic [SHW:0] STEP_C = (SHW+1)'(STEP);

  state_t state_q, state_d;

  logic [SHW:0]       remain_q, remain_d;
  logic [WIDTH-1:0]   work_q;
  logic               right_q, arith_q;
  logic [WIDTH-1:0]   y_q;
  logic               cout_q, ovf_q, zero_q, err_q;

  logic               bsel, cisel, shiftLa, shiftLr, logicalOa, isShift, illegal;
  logic [1:0]         osel;

  logic               accept, shiftLoad;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   bOp;
  logic [WIDTH:0]     sum;
  logic               addOvf;
  logic [WIDTH-1:0]   logicRes;
  logic [WIDTH-1:0]   acceptY;
  logic               acceptCout, acceptOvf;
  logic [SHW:0]       stepAmt;
  logic [WIDTH-1:0]   shiftRes, preShift;
  logic               shiftOut;

  alu_seq_decode u_decode (
    .FS         (FS),
    .BSEL       (bsel),
    .CISEL      (cisel),
    .OSEL       (osel),
    .SHIFT_LA   (shiftLa),
    .SHIFT_LR   (shiftLr),
    .LOGICAL_OA (logicalOa),
    .IS_SHIFT   (isShift),
    .ILLEGAL    (illegal)
  );

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign shamt     = B[SHW-1:0];
  assign shiftLoad = isShift && (shamt != '0);

  assign bOp      = bsel ? ~B : B;
  assign sum      = {1'b0, A} + {1'b0, bOp} + (WIDTH+1)'(cisel);
  assign addOvf   = (A[WIDTH-1] == bOp[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
  assign logicRes = logicalOa ? (A | B) : (A & B);

  always_comb begin
    acceptY    = '0;
    acceptCout = 1'b0;
    acceptOvf  = 1'b0;
    case (osel)
      OSEL_ADD: begin
        acceptY    = sum[WIDTH-1:0];
        acceptCout = sum[WIDTH];
        acceptOvf  = addOvf;
      end
      OSEL_SHIFT: acceptY = A;
      OSEL_LOGIC: acceptY = logicRes;
      default:    acceptY = '0;
    endcase
  end

  // preShift stops one bit short so its edge bit is the last bit shifted out
  always_comb begin
    stepAmt  = (remain_q > STEP_C) ? STEP_C : remain_q;
    remain_d = remain_q - stepAmt;
    shiftRes = '0;
    preShift = '0;
    shiftOut = 1'b0;
    if (right_q) begin
      if (arith_q) begin
        shiftRes = $signed(work_q) >>> stepAmt;
        preShift = $signed(work_q) >>> (stepAmt - 1'b1);
      end else begin
        shiftRes = work_q >> stepAmt;
        preShift = work_q >> (stepAmt - 1'b1);
      end
      shiftOut = preShift[0];
    end else begin
      shiftRes = work_q << stepAmt;
      preShift = work_q << (stepAmt - 1'b1);
      shiftOut = preShift[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = shiftLoad ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (remain_d == '0) state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Result registers move only at accept, on the final shift step, or at reset
  always_ff @(posedge clk) begin
    if (rst) begin
      remain_q <= '0;
      work_q   <= '0;
      right_q  <= 1'b0;
      arith_q  <= 1'b0;
      y_q      <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (accept) begin
      remain_q <= {1'b0, shamt};
      work_q   <= A;
      right_q  <= shiftLr;
      arith_q  <= shiftLa;
      if (!shiftLoad) begin
        y_q    <= acceptY;
        cout_q <= acceptCout;
        ovf_q  <= acceptOvf;
        zero_q <= (acceptY == '0);
        err_q  <= illegal;
      end
    end else if (state_q == ST_SHIFT) begin
      remain_q <= remain_d;
      work_q   <= shiftRes;
      if (remain_d == '0) begin
        y_q    <= shiftRes;
        cout_q <= shiftOut;
        ovf_q  <= 1'b0;
        zero_q <= (shiftRes == '0);
        err_q  <= 1'b0;
      end
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign Y         = y_q;
  assign COUT      = cout_q;
  assign OVF       = ovf_q;
  assign ZERO      = zero_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (STEP=1 main instance, STEP=4 latency instance).
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic [2:0]  FS;
  logic [15:0] A, B;
  logic        in_ready, out_valid, COUT, OVF, ZERO, ERR;
  logic [15:0] Y;

  logic        valid4, outReady4;
  logic        inReady4, outValid4, cout4, ovf4, zero4, err4;
  logic [15:0] y4;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(16), .STEP(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .FS(FS), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .Y(Y), .COUT(COUT), .OVF(OVF), .ZERO(ZERO), .ERR(ERR)
  );

  alu_seq #(.WIDTH(16), .STEP(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(valid4), .in_ready(inReady4),
    .FS(FS), .A(A), .B(B), .out_valid(outValid4), .out_ready(outReady4),
    .Y(y4), .COUT(cout4), .OVF(ovf4), .ZERO(zero4), .ERR(err4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Offers one operation from an idle DUT, then counts edges until out_valid
  task automatic applyStimulus(input logic [2:0] fs, input logic [15:0] a,
                               input logic [15:0] b, output int lat);
    checkOutput("in_ready before accept", {31'd0, in_ready}, 32'd1);
    FS = fs; A = a; B = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    FS = 3'($urandom); A = 16'($urandom); B = 16'($urandom);
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic runOp(input string tag, input logic [2:0] fs, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] expY,
                       input logic [3:0] expFlags, input int expLat);
    int lat;
    applyStimulus(fs, a, b, lat);
    checkOutput({tag, " latency"}, lat, expLat);
    checkOutput({tag, " Y"}, {16'd0, Y}, {16'd0, expY});
    checkOutput({tag, " flags"}, {28'd0, COUT, OVF, ZERO, ERR}, {28'd0, expFlags});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, " release"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  lat;
    logic seenValid;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; valid4 = 1'b0; outReady4 = 1'b1;
    FS = FS_ADD; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset handshake", {30'd0, out_valid, in_ready}, 32'd0);
    checkOutput("reset Y", {16'd0, Y}, 32'd0);
    checkOutput("reset flags", {28'd0, COUT, OVF, ZERO, ERR}, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("in_ready after reset", {31'd0, in_ready}, 32'd1);

    // flags are {COUT, OVF, ZERO, ERR}
    runOp("ADD ovf",     FS_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b0100, 1);
    runOp("SUB equal",   FS_SUB, 16'h0005, 16'h0005, 16'h0000, 4'b1010, 1);
    runOp("SUB borrow",  FS_SUB, 16'h0000, 16'h0001, 16'hFFFF, 4'b0000, 1);
    runOp("SUB ovf",     FS_SUB, 16'h8000, 16'h0001, 16'h7FFF, 4'b1100, 1);
    runOp("ADD carry",   FS_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010, 1);
    runOp("AND",         FS_AND, 16'hF0F0, 16'h3C3C, 16'h3030, 4'b0000, 1);
    runOp("OR",          FS_OR,  16'hF0F0, 16'h3C3C, 16'hFCFC, 4'b0000, 1);
    runOp("SRA 5",       FS_SRA, 16'h8010, 16'h0005, 16'hFC00, 4'b1000, 6);
    runOp("SRA pos",     FS_SRA, 16'h4000, 16'h0003, 16'h0800, 4'b0000, 4);
    runOp("SLL 15",      FS_SLL, 16'h0001, 16'h000F, 16'h8000, 4'b0000, 16);
    runOp("SRL 15",      FS_SRL, 16'h8000, 16'h000F, 16'h0001, 4'b0000, 16);
    runOp("SRA shamt0",  FS_SRA, 16'hABCD, 16'h0000, 16'hABCD, 4'b0000, 1);
    runOp("SRL upperB",  FS_SRL, 16'h0003, 16'hFFF1, 16'h0001, 4'b1000, 2);
    runOp("SLL cout",    FS_SLL, 16'hC000, 16'h0001, 16'h8000, 4'b1000, 2);
    runOp("SLL zero",    FS_SLL, 16'hC000, 16'h0002, 16'h0000, 4'b1010, 3);

    // Result must sit unchanged in DONE while an extra operation is offered
    applyStimulus(FS_ADD, 16'h1234, 16'h1111, lat);
    checkOutput("hold latency", lat, 32'd1);
    for (int i = 0; i < 5; i++) begin
      FS = FS_SUB; A = 16'h0000; B = 16'h0001; in_valid = 1'b1;
      @(posedge clk); #1;
      checkOutput("hold Y", {16'd0, Y}, 32'h2345);
      checkOutput("hold flags", {28'd0, COUT, OVF, ZERO, ERR}, 32'd0);
      checkOutput("hold handshake", {30'd0, out_valid, in_ready}, 32'd2);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    checkOutput("hold release", {30'd0, out_valid, in_ready}, 32'd1);
    @(posedge clk); #1;
    checkOutput("hold no accept", {30'd0, out_valid, in_ready}, 32'd1);
    checkOutput("hold Y kept", {16'd0, Y}, 32'h2345);

    // Reset in the third SHIFT cycle discards the pending shift
    FS = FS_SRL; A = 16'hFFFF; B = 16'h000A; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seenValid = out_valid;
    @(posedge clk); #1;
    seenValid |= out_valid;
    @(posedge clk); #1;
    seenValid |= out_valid;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("mid reset handshake", {30'd0, out_valid, in_ready}, 32'd0);
    checkOutput("mid reset Y", {16'd0, Y}, 32'd0);
    checkOutput("mid reset flags", {28'd0, COUT, OVF, ZERO, ERR}, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("mid reset in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      seenValid |= out_valid;
    end
    checkOutput("aborted result hidden", {31'd0, seenValid}, 32'd0);

    runOp("illegal",     FS_ILL, 16'h1234, 16'h5678, 16'h0000, 4'b0011, 1);

    // STEP=4 instance: shamt 5 takes a full step of 4 then a partial step of 1
    checkOutput("step4 ready", {31'd0, inReady4}, 32'd1);
    FS = FS_SRA; A = 16'h8010; B = 16'h0005; valid4 = 1'b1;
    @(posedge clk); #1;
    valid4 = 1'b0;
    lat = 1;
    while (!outValid4 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("step4 latency", lat, 32'd3);
    checkOutput("step4 Y", {16'd0, y4}, 32'hFC00);
    checkOutput("step4 flags", {28'd0, cout4, ovf4, zero4, err4}, 32'h8);
    @(posedge clk); #1;
    checkOutput("step4 release", {30'd0, outValid4, inReady4}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
